// File: rtl/mem_sys_pkg.sv
// -----------------------------------------------------------------------------
// mem_sys_pkg
// Shared types and constants for the memory subsystem (mem_sys_ctrl and
// mem_sys_gpio): address region tags, controller FSM states, I/O register
// offsets, the value returned by reads of unmapped space, and a helper that
// sizes the wait-state counter.
// -----------------------------------------------------------------------------
package mem_sys_pkg;

    // Address regions, listed in no particular order; decode priority is
    // applied by the controller (ROM > IO > RAM > unmapped).
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    // Access handshake FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Register offsets inside the 16-byte I/O window (addr[3:0]).
    localparam logic [3:0] IO_GPIO_OUT = 4'd0;
    localparam logic [3:0] IO_GPIO_IN  = 4'd1;
    localparam logic [3:0] IO_IRQ_STAT = 4'd2;
    localparam logic [3:0] IO_IRQ_MASK = 4'd3;

    // Read data returned for unmapped space; truncated to the data width.
    localparam logic [63:0] UNMAPPED_RDATA = '1;

    // Counter width able to hold the largest wait-state value (at least 1).
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/mem_sys_gpio.sv
// -----------------------------------------------------------------------------
// mem_sys_gpio
// GPIO block of the memory subsystem I/O window: output register, 2-flop
// input synchroniser plus an edge-detect flop, rising-edge interrupt status
// (write-1-to-clear), interrupt mask and a registered interrupt request.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-low reset
//   gpio_in    in   [DW] asynchronous external inputs
//   reg_wr     in   register write strobe (one cycle)
//   reg_off    in   [4]  register offset within the I/O window
//   reg_wdata  in   [DW] register write data
//   reg_rdata  out  [DW] register read data for reg_off (combinational)
//   gpio_out   out  [DW] output register
//   irq_out    out  registered |(IRQ_STAT & IRQ_MASK)
// -----------------------------------------------------------------------------
module mem_sys_gpio
    import mem_sys_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [DW-1:0] gpio_in,
    input  logic          reg_wr,
    input  logic [3:0]    reg_off,
    input  logic [DW-1:0] reg_wdata,
    output logic [DW-1:0] reg_rdata,
    output logic [DW-1:0] gpio_out,
    output logic          irq_out
);

    logic [DW-1:0] sync1, sync2, sync3;
    logic [DW-1:0] irq_stat, irq_mask;
    logic [DW-1:0] rise;
    logic [DW-1:0] w1c;

    assign rise = sync2 & ~sync3;
    assign w1c  = (reg_wr && reg_off == IO_IRQ_STAT) ? reg_wdata : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others (the synchroniser chain
    // depends on this).
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            gpio_out <= '0;
            irq_stat <= '0;
            irq_mask <= '0;
            irq_out  <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (reg_wr && reg_off == IO_GPIO_OUT) gpio_out <= reg_wdata;
            if (reg_wr && reg_off == IO_IRQ_MASK) irq_mask <= reg_wdata;
            // Clear first, then OR in new edges: a set in the same cycle wins.
            irq_stat <= (irq_stat & ~w1c) | rise;
            irq_out  <= |(irq_stat & irq_mask);
        end
    end

    // NOTE: a default assignment ahead of the case keeps this block free of
    // inferred latches for the unlisted offsets.
    always_comb begin
        reg_rdata = '0;
        unique case (reg_off)
            IO_GPIO_OUT: reg_rdata = gpio_out;
            IO_GPIO_IN:  reg_rdata = sync2;
            IO_IRQ_STAT: reg_rdata = irq_stat;
            IO_IRQ_MASK: reg_rdata = irq_mask;
            default:     reg_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_sys_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sys_ctrl
// Single addressed slave with four regions (RAM, ROM, I/O, unmapped), a
// per-region wait-state count and a rdy/ack handshake. The I/O window holds
// the GPIO block (mem_sys_gpio) whose interrupt drives irq_out.
//
// The access is carried out on the clock edge that enters ACK, so ack,
// rdata, bus_err and any register/memory write are all visible during the
// ack cycle, which is cycle T+1+W for an accept in cycle T.
//
// Build option: MEM_SYS_ROM_WP_EN
//   defined   - ROM writes are dropped and flagged with bus_err
//   undefined - ROM is writable like RAM, no error
//
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   synchronous active-low reset
//   req       in   access request, sampled only while rdy=1
//   rw        in   1=read, 0=write
//   addr      in   [AW] byte address, stable from accept to ack
//   wdata     in   [DW] write data, stable from accept to ack
//   rdy       out  slave idle, can accept a request
//   ack       out  one-cycle completion pulse
//   rdata     out  [DW] read data, valid with ack, held until the next ack
//   bus_err   out  one-cycle error pulse coincident with ack
//   gpio_in   in   [DW] asynchronous external inputs
//   gpio_out  out  [DW] GPIO output register
//   irq_out   out  level interrupt request
// -----------------------------------------------------------------------------
module mem_sys_ctrl
    import mem_sys_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          DW       = 8,
    parameter int          RAM_AW   = 15,
    parameter int          ROM_AW   = 12,
    parameter logic [AW-1:0] IO_BASE = 16'h8000,
    parameter int          WAIT_RAM = 0,
    parameter int          WAIT_ROM = 1,
    parameter int          WAIT_IO  = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req,
    input  logic          rw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          rdy,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          bus_err,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic          irq_out
);

`ifdef MEM_SYS_ROM_WP_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    localparam int WAIT_MAX = (WAIT_RAM > WAIT_ROM)
                            ? ((WAIT_RAM > WAIT_IO) ? WAIT_RAM : WAIT_IO)
                            : ((WAIT_ROM > WAIT_IO) ? WAIT_ROM : WAIT_IO);
    localparam int CW        = cnt_width(WAIT_MAX);
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam int ROM_DEPTH = 1 << ROM_AW;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          go_ack;

    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Values of the access in flight: live bus inputs in the accept cycle
    // (needed when W=0, where the access completes on the accept edge),
    // latched copies afterwards.
    logic          acc_rw;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    region_t       acc_region;

    logic [CW-1:0] wait_val;
    logic [DW-1:0] rd_val;
    logic          err_val;
    logic          io_wr;
    logic [DW-1:0] io_rdata;

    logic [DW-1:0] ram_mem [RAM_DEPTH];
    logic [DW-1:0] rom_mem [ROM_DEPTH];

    function automatic region_t decode(input logic [AW-1:0] a);
        if (&a[AW-1:ROM_AW])                return REG_ROM;
        if (a[AW-1:4] == IO_BASE[AW-1:4])   return REG_IO;
        if (a[AW-1:RAM_AW] == '0)           return REG_RAM;
        return REG_NONE;
    endfunction

    assign acc_rw     = (state == IDLE) ? rw    : rw_q;
    assign acc_addr   = (state == IDLE) ? addr  : addr_q;
    assign acc_wdata  = (state == IDLE) ? wdata : wdata_q;
    assign acc_region = decode(acc_addr);

    assign rdy = (state == IDLE);
    assign ack = (state == ACK);

    always_comb begin
        wait_val = '0;
        unique case (acc_region)
            REG_RAM: wait_val = CW'(WAIT_RAM);
            REG_ROM: wait_val = CW'(WAIT_ROM);
            default: wait_val = CW'(WAIT_IO);
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go_ack   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (wait_val == '0) begin
                        state_nx = ACK;
                        go_ack   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nx = ACK;
                    go_ack   = 1'b1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access datapath
    // ------------------------------------------------------------------
    always_comb begin
        rd_val = '0;
        unique case (acc_region)
            REG_RAM: rd_val = ram_mem[acc_addr[RAM_AW-1:0]];
            REG_ROM: rd_val = rom_mem[acc_addr[ROM_AW-1:0]];
            REG_IO:  rd_val = io_rdata;
            default: rd_val = DW'(UNMAPPED_RDATA);
        endcase
    end

    assign err_val = (acc_region == REG_NONE)
                   || (ROM_WP && acc_region == REG_ROM && !acc_rw);

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt     <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == IDLE && req) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= wait_val;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (go_ack) begin
                bus_err <= err_val;
                if (acc_rw) rdata <= rd_val;
            end
        end
    end

    // NOTE: the RAM/ROM arrays are deliberately left out of reset so they
    // map onto plain memory; reset only gates the write enable, which is
    // what makes an access aborted by clr leave memory untouched.
    always_ff @(posedge clk) begin
        if (clr && go_ack && !acc_rw) begin
            if (acc_region == REG_RAM)
                ram_mem[acc_addr[RAM_AW-1:0]] <= acc_wdata;
            if (acc_region == REG_ROM && !ROM_WP)
                rom_mem[acc_addr[ROM_AW-1:0]] <= acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // I/O window
    // ------------------------------------------------------------------
    assign io_wr = go_ack && !acc_rw && (acc_region == REG_IO);

    mem_sys_gpio #(
        .DW (DW)
    ) u_gpio (
        .clk       (clk),
        .clr       (clr),
        .gpio_in   (gpio_in),
        .reg_wr    (io_wr),
        .reg_off   (acc_addr[3:0]),
        .reg_wdata (acc_wdata),
        .reg_rdata (io_rdata),
        .gpio_out  (gpio_out),
        .irq_out   (irq_out)
    );

endmodule

// File: tb/tb_mem_sys_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sys_ctrl
// Directed bench for mem_sys_ctrl at default parameters. Inputs change and
// outputs are sampled 1 ns after each rising edge. Expected values are
// hand-computed constants; a ROM write-protect build (MEM_SYS_ROM_WP_EN)
// switches the ROM preload and the expected ROM-write outcome.
// -----------------------------------------------------------------------------
module tb_mem_sys_ctrl;

`ifdef MEM_SYS_ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rdy;
    logic        ack;
    logic [7:0]  rdata;
    logic        bus_err;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ops    = 0;
    int ack_cnt  = 0;

    mem_sys_ctrl dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .rdy      (rdy),
        .ack      (ack),
        .rdata    (rdata),
        .bus_err  (bus_err),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;

    // Count every completion pulse, independent of the access tasks.
    always @(negedge clk) if (ack === 1'b1) ack_cnt++;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access; returns in the ack cycle. lat = cycles from accept
    // edge to the ack cycle (1+W).
    task automatic bus_op(input logic r, input logic [15:0] a,
                          input logic [7:0] d, output logic [7:0] rd,
                          output logic err, output int lat);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (rdy !== 1'b1) check("rdy_timeout", 32'(rdy), 1);
        rw = r; addr = a; wdata = d; req = 1'b1;
        tick();
        req = 1'b0;
        lat = 1;
        while (ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (ack !== 1'b1) check("ack_timeout", 32'(ack), 1);
        rd  = rdata;
        err = bus_err;
        n_ops++;
    endtask

    task automatic op_chk(input string tag, input logic r,
                          input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input logic exp_err,
                          input int exp_lat);
        logic [7:0] rd;
        logic       err;
        int         lat;
        bus_op(r, a, d, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (r) check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         lat;
        int         acks_before;

        clr = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; wdata = '0;
        gpio_in = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_rdy",      32'(rdy),      1);
        check("rst_ack",      32'(ack),      0);
        check("rst_rdata",    32'(rdata),    0);
        check("rst_bus_err",  32'(bus_err),  0);
        check("rst_gpio_out", 32'(gpio_out), 0);
        check("rst_irq_out",  32'(irq_out),  0);
        clr = 1'b1;
        tick();

        // RAM, zero wait states
        op_chk("ram_wr", 1'b0, 16'h0022, 8'h55, 8'h00, 1'b0, 1);
        check("ram_busy_rdy", 32'(rdy), 0);
        tick();
        check("ram_idle_rdy", 32'(rdy), 1);
        op_chk("ram_rd", 1'b1, 16'h0022, 8'h00, 8'h55, 1'b0, 1);
        op_chk("ram_top", 1'b0, 16'h7FFF, 8'h9E, 8'h00, 1'b0, 1);
        op_chk("ram_top_rd", 1'b1, 16'h7FFF, 8'h00, 8'h9E, 1'b0, 1);

        // ROM vectors, one wait state
        if (WP) begin
            dut.rom_mem[12'hFFC] = 8'h57;
            dut.rom_mem[12'hFFD] = 8'h28;
        end else begin
            op_chk("rom_pre0", 1'b0, 16'hFFFC, 8'h57, 8'h00, 1'b0, 2);
            op_chk("rom_pre1", 1'b0, 16'hFFFD, 8'h28, 8'h00, 1'b0, 2);
        end
        op_chk("rom_rd0", 1'b1, 16'hFFFC, 8'h00, 8'h57, 1'b0, 2);
        op_chk("rom_rd1", 1'b1, 16'hFFFD, 8'h00, 8'h28, 1'b0, 2);
        op_chk("rom_wr", 1'b0, 16'hFFFC, 8'h00, 8'h00, WP, 2);
        op_chk("rom_reread", 1'b1, 16'hFFFC, 8'h00, WP ? 8'h57 : 8'h00,
               1'b0, 2);

        // Unmapped space and I/O, two wait states
        op_chk("unm_rd", 1'b1, 16'h9000, 8'h00, 8'hFF, 1'b1, 3);
        op_chk("unm_wr", 1'b0, 16'h9000, 8'h12, 8'h00, 1'b1, 3);
        op_chk("io_wr",  1'b0, 16'h8000, 8'hA5, 8'h00, 1'b0, 3);
        check("io_gpio_out_at_ack", 32'(gpio_out), 32'h0A5);
        op_chk("io_rd",  1'b1, 16'h8000, 8'h00, 8'hA5, 1'b0, 3);
        op_chk("io_off5", 1'b1, 16'h8005, 8'h00, 8'h00, 1'b0, 3);
        op_chk("ram_after_io", 1'b1, 16'h0022, 8'h00, 8'h55, 1'b0, 1);

        // Interrupt: rising edge on gpio_in[0], mask bit 0
        op_chk("mask_wr", 1'b0, 16'h8003, 8'h01, 8'h00, 1'b0, 3);
        gpio_in = 8'h01;
        repeat (3) tick();
        check("irq_not_yet", 32'(irq_out), 0);
        tick();
        check("irq_set", 32'(irq_out), 1);
        op_chk("stat_rd", 1'b1, 16'h8002, 8'h00, 8'h01, 1'b0, 3);
        op_chk("gpio_in_rd", 1'b1, 16'h8001, 8'h00, 8'h01, 1'b0, 3);
        op_chk("stat_w1c", 1'b0, 16'h8002, 8'h01, 8'h00, 1'b0, 3);
        tick();
        check("irq_cleared", 32'(irq_out), 0);
        op_chk("stat_rd_clr", 1'b1, 16'h8002, 8'h00, 8'h00, 1'b0, 3);

        // Masked-off edge sets status but not irq_out
        gpio_in = 8'h03;
        repeat (5) tick();
        check("irq_masked", 32'(irq_out), 0);
        op_chk("stat_rd_b1", 1'b1, 16'h8002, 8'h00, 8'h02, 1'b0, 3);
        op_chk("stat_w1c_b1", 1'b0, 16'h8002, 8'h02, 8'h00, 1'b0, 3);

        // Set wins over W1C: the edge lands on the edge that enters ACK
        gpio_in = 8'h00;
        repeat (5) tick();
        gpio_in = 8'h01;
        op_chk("w1c_race", 1'b0, 16'h8002, 8'h01, 8'h00, 1'b0, 3);
        op_chk("stat_rd_race", 1'b1, 16'h8002, 8'h00, 8'h01, 1'b0, 3);
        check("irq_race", 32'(irq_out), 1);
        op_chk("stat_cleanup", 1'b0, 16'h8002, 8'h01, 8'h00, 1'b0, 3);
        op_chk("mask_cleanup", 1'b0, 16'h8003, 8'h00, 8'h00, 1'b0, 3);

        // Reset in WAIT aborts an I/O write
        tick();
        acks_before = ack_cnt;
        rw = 1'b0; addr = 16'h8000; wdata = 8'h3C; req = 1'b1;
        tick();
        check("abort_in_wait_rdy", 32'(rdy), 0);
        req = 1'b0;
        clr = 1'b0;
        tick();
        check("abort_rdy", 32'(rdy), 1);
        check("abort_ack", 32'(ack), 0);
        check("abort_gpio_rst", 32'(gpio_out), 0);
        clr = 1'b1;
        repeat (3) tick();
        check("abort_gpio_hold", 32'(gpio_out), 0);
        check("abort_no_ack", 32'(ack_cnt), 32'(acks_before));

        // req held while busy is not accepted twice
        rw = 1'b1; addr = 16'h8000; req = 1'b1;
        tick();
        lat = 1;
        while (ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rd = rdata;
        err = bus_err;
        n_ops++;
        req = 1'b0;
        check("hold_lat", 32'(lat), 3);
        check("hold_rdata", 32'(rd), 0);
        check("hold_err", 32'(err), 0);
        repeat (4) tick();
        check("hold_rdy", 32'(rdy), 1);
        check("ack_count", 32'(ack_cnt), 32'(n_ops));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
